// File: rtl/sd_cmd_serializer.sv
// sd_cmd_serializer: builds the 48-bit SD CMD token from an index and argument
// and shifts it MSB-first to the CMD pad, one bit per sd_clock, followed by a
// minimum idle gap of GAP_CYCLES cycles.
// Optional macro SD_CMD_CRC_EN: when defined the CRC7 field is computed
// serially; when undefined the CRC field is sent as all ones.
module sd_cmd_serializer #(
  parameter int GAP_CYCLES = 8
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        ready,
  output logic        done,
  output logic        pad_data,
  output logic        pad_enable,
  output logic        pad_output_input
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [5:0]    bitCnt_q, bitCnt_d;
  logic [GW-1:0] gapCnt_q, gapCnt_d;
  logic [38:0]   shift_q, shift_d;
  logic          padData_q, padData_d;
  logic          padEn_q, padEn_d;
  logic          padOe_q, padOe_d;
  logic          done_q, done_d;
  logic          crcOut;

`ifdef SD_CMD_CRC_EN
  logic [6:0] crc_q, crc_d;
  logic       crcFb;

  assign crcOut = crc_q[6];
  assign crcFb  = crc_q[6] ^ shift_q[38];
`else
  assign crcOut = 1'b1;
`endif

  assign ready            = (state_q == IDLE);
  assign done             = done_q;
  assign pad_data         = padData_q;
  assign pad_enable       = padEn_q;
  assign pad_output_input = padOe_q;

  // Next-state logic: frame capture, bit sequencing, CRC and gap counting.
  // bitCnt_q holds the frame index of the bit currently on pad_data; the
  // shift register holds the remaining header bits 46..8 with the next at [38].
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    gapCnt_d  = gapCnt_q;
    shift_d   = shift_q;
    padData_d = padData_q;
    padEn_d   = padEn_q;
    padOe_d   = padOe_q;
    done_d    = 1'b0;
`ifdef SD_CMD_CRC_EN
    crc_d     = crc_q;
`endif
    case (state_q)
      IDLE: begin
        padData_d = 1'b1;
        padEn_d   = 1'b0;
        padOe_d   = 1'b0;
        if (start) begin
          // The start bit (frame bit 47) goes out immediately. It is a zero,
          // so folding it into a zero-initialised CRC leaves the CRC at zero.
          shift_d   = {1'b1, cmd_index, cmd_arg};
          bitCnt_d  = 6'd47;
          padData_d = 1'b0;
          padEn_d   = 1'b1;
          padOe_d   = 1'b1;
          state_d   = SEND;
`ifdef SD_CMD_CRC_EN
          crc_d     = 7'd0;
`endif
        end
      end
      SEND: begin
        if (bitCnt_q == 6'd0) begin
          padData_d = 1'b1;
          padEn_d   = 1'b0;
          padOe_d   = 1'b0;
          done_d    = 1'b1;
          if (GAP_CYCLES > 0) begin
            gapCnt_d = GAP_LOAD;
            state_d  = GAP;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          bitCnt_d = bitCnt_q - 6'd1;
          if (bitCnt_q > 6'd8) begin
            padData_d = shift_q[38];
            shift_d   = {shift_q[37:0], 1'b0};
`ifdef SD_CMD_CRC_EN
            crc_d     = {crc_q[5:3], crc_q[2] ^ crcFb, crc_q[1:0], crcFb};
`endif
          end else if (bitCnt_q > 6'd1) begin
            padData_d = crcOut;
`ifdef SD_CMD_CRC_EN
            crc_d     = {crc_q[5:0], 1'b0};
`endif
          end else begin
            padData_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (gapCnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gapCnt_d = gapCnt_q - GW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        padData_d = 1'b1;
        padEn_d   = 1'b0;
        padOe_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any partial frame.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bitCnt_q  <= 6'd0;
      gapCnt_q  <= '0;
      shift_q   <= '0;
      padData_q <= 1'b1;
      padEn_q   <= 1'b0;
      padOe_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef SD_CMD_CRC_EN
      crc_q     <= 7'd0;
`endif
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      gapCnt_q  <= gapCnt_d;
      shift_q   <= shift_d;
      padData_q <= padData_d;
      padEn_q   <= padEn_d;
      padOe_q   <= padOe_d;
      done_q    <= done_d;
`ifdef SD_CMD_CRC_EN
      crc_q     <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Testbench for sd_cmd_serializer: one instance with an 8-cycle gap and one
// with no gap, checked against a token model built by polynomial division.
module tb_sd_cmd_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        aStart, aReady, aDone, aData, aEn, aOe;
  logic [5:0]  aIdx;
  logic [31:0] aArg;
  logic        bStart, bReady, bDone, bData, bEn, bOe;
  logic [5:0]  bIdx;
  logic [31:0] bArg;

  int checks   = 0;
  int failures = 0;

  sd_cmd_serializer #(.GAP_CYCLES(8)) dutA (
    .sd_clock(clk), .reset(reset), .start(aStart), .cmd_index(aIdx), .cmd_arg(aArg),
    .ready(aReady), .done(aDone), .pad_data(aData), .pad_enable(aEn),
    .pad_output_input(aOe)
  );

  sd_cmd_serializer #(.GAP_CYCLES(0)) dutB (
    .sd_clock(clk), .reset(reset), .start(bStart), .cmd_index(bIdx), .cmd_arg(bArg),
    .ready(bReady), .done(bDone), .pad_data(bData), .pad_enable(bEn),
    .pad_output_input(bOe)
  );

  // Reference token: header, CRC7 as remainder of header*x^7 mod x^7+x^3+1, end bit.
  function automatic logic [47:0] expectToken(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    logic [6:0]  crc;
    logic [46:0] rem;
    msg = {2'b01, idx, arg};
`ifdef SD_CMD_CRC_EN
    rem = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem = rem ^ (47'h89 << (i - 7));
    crc = rem[6:0];
`else
    rem = '0;
    crc = 7'h7F;
`endif
    return {msg, crc, 1'b1};
  endfunction

  // Drives one command on instance A and records what the pad outputs did.
  task automatic captureA(input logic [5:0] idx, input logic [31:0] arg,
                          input int p1, input int p2,
                          output logic [47:0] bits, output int enInFrame, output int enTotal,
                          output int doneCount, output int doneAt, output int readyAt,
                          output int badIdle, output int timedOut);
    int w;
    bits = '0; enInFrame = 0; enTotal = 0; doneCount = 0; doneAt = 0;
    readyAt = 0; badIdle = 0; timedOut = 0; w = 0;
    @(negedge clk);
    while (!aReady && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!aReady) begin
      timedOut = 1;
      return;
    end
    aIdx = idx; aArg = arg; aStart = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      aStart = (c == p1 || c == p2);
      if (c <= 48) begin
        bits[48 - c] = aData;
        if (aEn && aOe) enInFrame++;
      end
      if (aEn) enTotal++;
      if (!aEn && (aData !== 1'b1 || aOe !== 1'b0)) badIdle++;
      if (aDone) begin
        doneCount++;
        doneAt = c;
      end
      if (c > 48 && aReady && readyAt == 0) readyAt = c;
    end
    aStart = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (aReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_readyA got=%b want=1", aReady); end
    checks++; if (aData !== 1'b1) begin failures++; $display("[TB] FAIL reset_dataA got=%b want=1", aData); end
    checks++; if ({aEn, aOe, aDone} !== 3'b000) begin failures++; $display("[TB] FAIL reset_ctlA got=%b want=000", {aEn, aOe, aDone}); end
    checks++; if ({bReady, bData, bEn, bOe, bDone} !== 5'b11000) begin failures++; $display("[TB] FAIL reset_B got=%b want=11000", {bReady, bData, bEn, bOe, bDone}); end
    reset = 1'b0;
  endtask

  task automatic test_cmd0;
    logic [47:0] bits;
    int enIn, enTot, dCnt, dAt, rAt, bad, to;
    captureA(6'd0, 32'h0, 0, 0, bits, enIn, enTot, dCnt, dAt, rAt, bad, to);
    checks++; if (to != 0) begin failures++; $display("[TB] FAIL cmd0_timeout got=%0d want=0", to); end
    checks++; if (bits !== expectToken(6'd0, 32'h0)) begin failures++; $display("[TB] FAIL cmd0_bits got=%h want=%h", bits, expectToken(6'd0, 32'h0)); end
`ifdef SD_CMD_CRC_EN
    checks++; if (bits !== 48'h400000000095) begin failures++; $display("[TB] FAIL cmd0_literal got=%h want=400000000095", bits); end
`else
    checks++; if (bits !== 48'h4000000000FF) begin failures++; $display("[TB] FAIL cmd0_literal got=%h want=4000000000ff", bits); end
`endif
    checks++; if (enIn != 48) begin failures++; $display("[TB] FAIL cmd0_en_in_frame got=%0d want=48", enIn); end
    checks++; if (enTot != 48) begin failures++; $display("[TB] FAIL cmd0_en_total got=%0d want=48", enTot); end
    checks++; if (dCnt != 1 || dAt != 49) begin failures++; $display("[TB] FAIL cmd0_done count=%0d at=%0d want 1 at 49", dCnt, dAt); end
    checks++; if (rAt != 57) begin failures++; $display("[TB] FAIL cmd0_ready_at got=%0d want=57", rAt); end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL cmd0_idle_pad got=%0d want=0", bad); end
  endtask

  task automatic test_cmd8;
    logic [47:0] bits;
    int enIn, enTot, dCnt, dAt, rAt, bad, to;
    captureA(6'd8, 32'h000001AA, 0, 0, bits, enIn, enTot, dCnt, dAt, rAt, bad, to);
    checks++; if (bits !== expectToken(6'd8, 32'h000001AA)) begin failures++; $display("[TB] FAIL cmd8_bits got=%h want=%h", bits, expectToken(6'd8, 32'h000001AA)); end
`ifdef SD_CMD_CRC_EN
    checks++; if (bits !== 48'h48000001AA87) begin failures++; $display("[TB] FAIL cmd8_literal got=%h want=48000001aa87", bits); end
`endif
    checks++; if (dCnt != 1 || dAt != 49 || to != 0) begin failures++; $display("[TB] FAIL cmd8_done count=%0d at=%0d to=%0d want 1 at 49", dCnt, dAt, to); end
  endtask

  task automatic test_start_busy;
    logic [47:0] bits;
    int enIn, enTot, dCnt, dAt, rAt, bad, to;
    captureA(6'd17, 32'h0, 10, 30, bits, enIn, enTot, dCnt, dAt, rAt, bad, to);
    checks++; if (bits !== expectToken(6'd17, 32'h0)) begin failures++; $display("[TB] FAIL busy_bits got=%h want=%h", bits, expectToken(6'd17, 32'h0)); end
    checks++; if (dCnt != 1) begin failures++; $display("[TB] FAIL busy_done_count got=%0d want=1", dCnt); end
    checks++; if (enTot != 48 || rAt != 57) begin failures++; $display("[TB] FAIL busy_en_ready en=%0d ready_at=%0d want 48/57", enTot, rAt); end
  endtask

  task automatic test_reset_midframe;
    logic [47:0] bits;
    int enIn, enTot, dCnt, dAt, rAt, bad, to;
    int enSeen, doneSeen, w;
    enSeen = 0; doneSeen = 0; w = 0;
    @(negedge clk);
    while (!aReady && w < 200) begin
      @(negedge clk);
      w++;
    end
    aIdx = 6'd17; aArg = $urandom; aStart = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      aStart = 1'b0;
      if (aEn) enSeen++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (enSeen != 19) begin failures++; $display("[TB] FAIL mid_pre_en got=%0d want=19", enSeen); end
    checks++; if ({aEn, aOe, aData, aDone, aReady} !== 5'b00101) begin failures++; $display("[TB] FAIL mid_reset_pad got=%b want=00101", {aEn, aOe, aData, aDone, aReady}); end
    reset = 1'b0;
    enSeen = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (aDone) doneSeen++;
      if (aEn) enSeen++;
    end
    checks++; if (doneSeen != 0 || enSeen != 0) begin failures++; $display("[TB] FAIL mid_after done=%0d en=%0d want 0/0", doneSeen, enSeen); end
    captureA(6'd0, 32'h0, 0, 0, bits, enIn, enTot, dCnt, dAt, rAt, bad, to);
    checks++; if (bits !== expectToken(6'd0, 32'h0) || dCnt != 1) begin failures++; $display("[TB] FAIL mid_recover bits=%h done=%0d want %h/1", bits, dCnt, expectToken(6'd0, 32'h0)); end
  endtask

  task automatic test_random;
    logic [47:0] bits, want;
    logic [5:0]  idx;
    logic [31:0] arg;
    int enIn, enTot, dCnt, dAt, rAt, bad, to;
    for (int n = 0; n < 6; n++) begin
      idx = 6'($urandom);
      arg = $urandom;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      captureA(idx, arg, 0, 0, bits, enIn, enTot, dCnt, dAt, rAt, bad, to);
      want = expectToken(idx, arg);
      checks++; if (bits !== want) begin failures++; $display("[TB] FAIL rand_bits n=%0d got=%h want=%h", n, bits, want); end
      checks++; if (enTot != 48 || dAt != 49 || rAt != 57 || bad != 0) begin failures++; $display("[TB] FAIL rand_timing n=%0d en=%0d done=%0d ready=%0d bad=%0d want 48/49/57/0", n, enTot, dAt, rAt, bad); end
    end
  endtask

  task automatic test_back_to_back;
    logic [47:0] b1, b2, w1, w2;
    logic [5:0]  i1, i2;
    logic [31:0] a1, a2;
    int enLow, enTot, dCnt, d1, d2, w;
    i1 = 6'($urandom); i2 = 6'($urandom); a1 = $urandom; a2 = $urandom;
    w1 = expectToken(i1, a1); w2 = expectToken(i2, a2);
    b1 = '0; b2 = '0; enLow = 0; enTot = 0; dCnt = 0; d1 = 0; d2 = 0; w = 0;
    @(negedge clk);
    while (!bReady && w < 200) begin
      @(negedge clk);
      w++;
    end
    bIdx = i1; bArg = a1; bStart = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      if (c == 1) begin bIdx = i2; bArg = a2; end
      if (c == 50) bStart = 1'b0;
      if (c <= 48) b1[48 - c] = bData;
      if (c >= 50 && c <= 97) b2[97 - c] = bData;
      if (c <= 97 && !bEn) enLow++;
      if (bEn) enTot++;
      if (bDone) begin
        dCnt++;
        if (d1 == 0) d1 = c; else d2 = c;
      end
    end
    bStart = 1'b0;
    checks++; if (b1 !== w1) begin failures++; $display("[TB] FAIL b2b_frame1 got=%h want=%h", b1, w1); end
    checks++; if (b2 !== w2) begin failures++; $display("[TB] FAIL b2b_frame2 got=%h want=%h", b2, w2); end
    checks++; if (enLow != 1) begin failures++; $display("[TB] FAIL b2b_en_low got=%0d want=1", enLow); end
    checks++; if (dCnt != 2 || d1 != 49 || d2 != 98) begin failures++; $display("[TB] FAIL b2b_done count=%0d at=%0d,%0d want 2 at 49,98", dCnt, d1, d2); end
    checks++; if (enTot != 96) begin failures++; $display("[TB] FAIL b2b_en_total got=%0d want=96", enTot); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    aStart = 1'b0; aIdx = '0; aArg = '0;
    bStart = 1'b0; bIdx = '0; bArg = '0;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_start_busy();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
